// File: rtl/mesi_snoop_bus_if.sv
// rtl/mesi_snoop_bus_if.sv - request/response, snoop and memory signals of the MESI snoop interconnect.
// Vectors are flattened per core: core i owns bits [i*W +: W].
interface mesi_snoop_bus_if #(
  parameter int NCORES = 4,
  parameter int AW     = 32,
  parameter int DW     = 32
);
  localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;

  logic [NCORES-1:0]    req_valid;
  logic [NCORES-1:0]    req_ready;
  logic [NCORES*2-1:0]  req_op;
  logic [NCORES*AW-1:0] req_addr;
  logic [NCORES*DW-1:0] req_wdata;
  logic [NCORES-1:0]    resp_valid;
  logic [DW-1:0]        resp_data;
  logic                 resp_shared;

  logic                 snoop_valid;
  logic [1:0]           snoop_op;
  logic [AW-1:0]        snoop_addr;
  logic [IW-1:0]        snoop_src;
  logic [NCORES-1:0]    snoop_done;
  logic [NCORES-1:0]    snoop_hit;
  logic [NCORES-1:0]    snoop_dirty;
  logic [NCORES*DW-1:0] snoop_data;

  logic                 mem_rd;
  logic                 mem_wr;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_wdata;
  logic [DW-1:0]        mem_rdata;
  logic                 mem_ack;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata,
    input  snoop_done, snoop_hit, snoop_dirty, snoop_data,
    input  mem_rdata, mem_ack,
    output req_ready, resp_valid, resp_data, resp_shared,
    output snoop_valid, snoop_op, snoop_addr, snoop_src,
    output mem_rd, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata,
    output snoop_done, snoop_hit, snoop_dirty, snoop_data,
    output mem_rdata, mem_ack,
    input  req_ready, resp_valid, resp_data, resp_shared,
    input  snoop_valid, snoop_op, snoop_addr, snoop_src,
    input  mem_rd, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mesi_snoop_bus.sv
// rtl/mesi_snoop_bus.sv - round-robin MESI snooping interconnect for NCORES cores.
// One transaction at a time: arbitrate, broadcast snoop, flush dirty owner or read memory, respond.
module mesi_snoop_bus #(
  parameter int NCORES = 4,
  parameter int AW     = 32,
  parameter int DW     = 32
) (
  input logic             clk,
  input logic             reset,
  mesi_snoop_bus_if.slave bus
);
  localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_RDX  = 2'b01;
  localparam logic [1:0] OP_UPGR = 2'b10;
  localparam logic [1:0] OP_WB   = 2'b11;

  typedef enum logic [1:0] {IDLE, SNOOP, MEM, RESP} state_t;

  state_t            state, state_n;
  logic [IW-1:0]     last_grant;
  logic [IW-1:0]     grant_idx;
  logic              any_req;
  logic [1:0]        req_op_g;
  logic [AW-1:0]     req_addr_g;
  logic [DW-1:0]     req_wdata_g;

  logic [1:0]        op_q;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     wdata_q;
  logic [DW-1:0]     line_q;
  logic [IW-1:0]     src_q;
  logic              mem_wr_q;
  logic              shared_q;

  logic [NCORES-1:0] done_mask;
  logic [NCORES-1:0] hit_q;
  logic [NCORES-1:0] dirty_q;
  logic [DW-1:0]     data_q [NCORES];

  logic [NCORES-1:0] src_mask;
  logic [NCORES-1:0] eff_hit;
  logic [NCORES-1:0] eff_dirty;
  logic [DW-1:0]     eff_data [NCORES];
  logic              all_done;
  logic              any_dirty;
  logic              snoop_shared;
  logic [IW-1:0]     owner;

  // Round-robin: search starts one past the last granted core.
  always_comb begin
    int j;
    j         = 0;
    any_req   = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NCORES; k++) begin
      j = (int'(last_grant) + k) % NCORES;
      if (!any_req && bus.req_valid[j]) begin
        any_req   = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

  always_comb begin
    req_op_g    = bus.req_op[int'(grant_idx)*2 +: 2];
    req_addr_g  = bus.req_addr[int'(grant_idx)*AW +: AW];
    req_wdata_g = bus.req_wdata[int'(grant_idx)*DW +: DW];
  end

  // Responses already recorded take precedence; otherwise use this cycle's done.
  always_comb begin
    src_mask        = '0;
    src_mask[src_q] = 1'b1;
    for (int i = 0; i < NCORES; i++) begin
      eff_hit[i]   = done_mask[i] ? hit_q[i]   : (bus.snoop_done[i] & bus.snoop_hit[i]);
      eff_dirty[i] = done_mask[i] ? dirty_q[i] : (bus.snoop_done[i] & bus.snoop_dirty[i]);
      eff_data[i]  = done_mask[i] ? data_q[i]  : bus.snoop_data[i*DW +: DW];
    end
    all_done     = &(done_mask | bus.snoop_done | src_mask);
    snoop_shared = |(eff_hit & ~src_mask);
    any_dirty    = 1'b0;
    owner        = '0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      if (eff_dirty[i] && !src_mask[i]) begin
        any_dirty = 1'b1;
        owner     = IW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (any_req) state_n = (req_op_g == OP_WB) ? MEM : SNOOP;
      SNOOP: if (all_done) state_n = (op_q == OP_UPGR) ? RESP : MEM;
      MEM:   if (bus.mem_ack) state_n = RESP;
      RESP:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready   = '0;
    bus.resp_valid  = '0;
    bus.resp_data   = '0;
    bus.resp_shared = 1'b0;
    bus.snoop_valid = (state == SNOOP);
    bus.snoop_op    = op_q;
    bus.snoop_addr  = addr_q;
    bus.snoop_src   = src_q;
    bus.mem_rd      = (state == MEM) && !mem_wr_q;
    bus.mem_wr      = (state == MEM) && mem_wr_q;
    bus.mem_addr    = (state == MEM) ? addr_q : '0;
    bus.mem_wdata   = (state == MEM && mem_wr_q) ? wdata_q : '0;
    if (state == IDLE && any_req && !reset) bus.req_ready[grant_idx] = 1'b1;
    if (state == RESP) begin
      bus.resp_valid[src_q] = 1'b1;
      bus.resp_data         = (op_q == OP_RD || op_q == OP_RDX) ? line_q : '0;
      bus.resp_shared       = (op_q == OP_RD) && shared_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= IW'(NCORES - 1);
      op_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      line_q     <= '0;
      src_q      <= '0;
      mem_wr_q   <= 1'b0;
      shared_q   <= 1'b0;
      done_mask  <= '0;
      hit_q      <= '0;
      dirty_q    <= '0;
      for (int i = 0; i < NCORES; i++) data_q[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            op_q      <= req_op_g;
            addr_q    <= req_addr_g;
            wdata_q   <= req_wdata_g;
            src_q     <= grant_idx;
            line_q    <= '0;
            shared_q  <= 1'b0;
            mem_wr_q  <= (req_op_g == OP_WB);
            done_mask <= '0;
          end
        end
        SNOOP: begin
          // First done from each core is kept; a held done does not overwrite it.
          for (int i = 0; i < NCORES; i++) begin
            if (bus.snoop_done[i] && !done_mask[i] && !src_mask[i]) begin
              done_mask[i] <= 1'b1;
              hit_q[i]     <= bus.snoop_hit[i];
              dirty_q[i]   <= bus.snoop_dirty[i];
              data_q[i]    <= bus.snoop_data[i*DW +: DW];
            end
          end
          if (all_done) begin
            shared_q <= snoop_shared;
            if (any_dirty && op_q != OP_UPGR) begin
              wdata_q  <= eff_data[owner];
              line_q   <= eff_data[owner];
              mem_wr_q <= 1'b1;
            end else begin
              mem_wr_q <= 1'b0;
            end
          end
        end
        MEM: begin
          if (bus.mem_ack && !mem_wr_q) line_q <= bus.mem_rdata;
        end
        RESP: last_grant <= src_q;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mesi_snoop_bus.sv
// tb/tb_mesi_snoop_bus.sv - directed self-checking bench for mesi_snoop_bus (4 cores).
module tb_mesi_snoop_bus;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   rd_cycles = 0;
  int   wr_cycles = 0;
  int   both_cycles = 0;
  int   rd_base, wr_base;

  mesi_snoop_bus_if #(.NCORES(4), .AW(32), .DW(32)) bus ();

  mesi_snoop_bus #(.NCORES(4), .AW(32), .DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_rd) rd_cycles++;
    if (bus.mem_wr) wr_cycles++;
    if (bus.mem_rd && bus.mem_wr) both_cycles++;
  end

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus.req_valid   = '0;
    bus.req_op      = '0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.snoop_done  = '0;
    bus.snoop_hit   = '0;
    bus.snoop_dirty = '0;
    bus.snoop_data  = '0;
    bus.mem_rdata   = '0;
    bus.mem_ack     = 1'b0;
    cyc; cyc;

    bus.req_valid = 4'b1111; #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_snoop_valid", bus.snoop_valid, 0);
    chk("rst_mem_rd", bus.mem_rd, 0);
    chk("rst_mem_wr", bus.mem_wr, 0);
    bus.req_valid = '0;
    reset = 1'b0;

    // BusRd core0 from memory, ack three cycles after mem_rd rises
    bus.req_addr = {32'h0, 32'h0, 32'h0, 32'h40};
    bus.req_valid = 4'b0001;
    bus.snoop_done = 4'b1110;
    rd_base = rd_cycles; wr_base = wr_cycles; #1;
    chk("a_ready", bus.req_ready, 4'b0001);
    cyc; bus.req_valid = '0; #1;
    chk("a_snoop_valid", bus.snoop_valid, 1);
    chk("a_snoop_addr", bus.snoop_addr, 32'h40);
    chk("a_snoop_src", bus.snoop_src, 0);
    cyc; bus.snoop_done = '0; #1;
    chk("a_mem_rd", bus.mem_rd, 1);
    chk("a_mem_addr", bus.mem_addr, 32'h40);
    cyc; cyc; cyc;
    bus.mem_rdata = 32'hDEADBEEF; bus.mem_ack = 1'b1; #1;
    chk("a_mem_rd_held", bus.mem_rd, 1);
    cyc; bus.mem_ack = 1'b0; #1;
    chk("a_resp_valid", bus.resp_valid, 4'b0001);
    chk("a_resp_data", bus.resp_data, 32'hDEADBEEF);
    chk("a_resp_shared", bus.resp_shared, 0);
    chk("a_mem_rd_drop", bus.mem_rd, 0);
    cyc; #1;
    chk("a_resp_pulse", bus.resp_valid, 0);
    chk("a_rd_cycles", rd_cycles - rd_base, 4);
    chk("a_wr_cycles", wr_cycles - wr_base, 0);

    // Arbitration after reset: 0, 2, 3 then 1 before 3
    reset = 1'b1; cyc; reset = 1'b0;
    bus.req_op = 8'hAA;
    bus.snoop_done = 4'b1111;
    bus.req_valid = 4'b1101; #1;
    chk("b_grant0", bus.req_ready, 4'b0001);
    cyc; bus.req_valid = 4'b1100; #1;
    chk("b_snoop_valid", bus.snoop_valid, 1);
    cyc; #1;
    chk("b_upgr_resp", bus.resp_valid, 4'b0001);
    chk("b_upgr_data", bus.resp_data, 0);
    cyc; #1;
    chk("b_grant2", bus.req_ready, 4'b0100);
    cyc; bus.req_valid = 4'b1000;
    cyc; cyc; #1;
    chk("b_grant3", bus.req_ready, 4'b1000);
    cyc; bus.req_valid = '0;
    cyc; #1;
    chk("b_resp3", bus.resp_valid, 4'b1000);
    cyc; bus.req_valid = 4'b1010; #1;
    chk("b_grant1_first", bus.req_ready, 4'b0010);
    cyc; bus.req_valid = 4'b1000;
    cyc; cyc; #1;
    chk("b_grant3_after1", bus.req_ready, 4'b1000);
    cyc; bus.req_valid = '0;
    cyc; cyc;

    // BusRd core1, core2 dirty owner, core3 hit; requester's own dirty bit is ignored
    bus.req_op = 8'h00;
    bus.req_addr = {32'h0, 32'h0, 32'h80, 32'h0};
    bus.snoop_done = 4'b1111;
    bus.snoop_hit = 4'b1110;
    bus.snoop_dirty = 4'b0110;
    bus.snoop_data = {32'h0, 32'h12345678, 32'hBAD0BAD0, 32'h0};
    bus.req_valid = 4'b0010;
    rd_base = rd_cycles; wr_base = wr_cycles; #1;
    chk("c_ready", bus.req_ready, 4'b0010);
    cyc; bus.req_valid = '0; #1;
    chk("c_snoop_src", bus.snoop_src, 1);
    cyc; #1;
    chk("c_mem_wr", bus.mem_wr, 1);
    chk("c_mem_rd", bus.mem_rd, 0);
    chk("c_mem_wdata", bus.mem_wdata, 32'h12345678);
    chk("c_mem_addr", bus.mem_addr, 32'h80);
    bus.mem_ack = 1'b1;
    cyc; bus.mem_ack = 1'b0;
    bus.snoop_done = '0; bus.snoop_hit = '0; bus.snoop_dirty = '0; #1;
    chk("c_resp_valid", bus.resp_valid, 4'b0010);
    chk("c_resp_data", bus.resp_data, 32'h12345678);
    chk("c_resp_shared", bus.resp_shared, 1);
    chk("c_no_mem_rd", rd_cycles - rd_base, 0);
    cyc;

    // BusUpgr core3 with staggered done pulses at cycles 1, 4, 2
    bus.req_op = 8'h80;
    bus.req_addr = {32'hC0, 32'h0, 32'h0, 32'h0};
    bus.snoop_hit = 4'b0001;
    bus.req_valid = 4'b1000;
    rd_base = rd_cycles; wr_base = wr_cycles; #1;
    chk("d_ready", bus.req_ready, 4'b1000);
    cyc; bus.req_valid = '0; bus.snoop_done = 4'b0001; #1;
    chk("d_sv_c1", bus.snoop_valid, 1);
    cyc; bus.snoop_done = 4'b0100; #1;
    chk("d_sv_c2", bus.snoop_valid, 1);
    cyc; bus.snoop_done = 4'b0000; #1;
    chk("d_sv_c3", bus.snoop_valid, 1);
    cyc; bus.snoop_done = 4'b0010; #1;
    chk("d_sv_c4", bus.snoop_valid, 1);
    cyc; bus.snoop_done = '0; #1;
    chk("d_sv_c5", bus.snoop_valid, 0);
    chk("d_resp_valid", bus.resp_valid, 4'b1000);
    chk("d_resp_data", bus.resp_data, 0);
    chk("d_resp_shared", bus.resp_shared, 0);
    chk("d_no_mem", (rd_cycles - rd_base) + (wr_cycles - wr_base), 0);
    cyc; bus.snoop_hit = '0;

    // WriteBack core2 goes straight to memory
    bus.req_op = 8'h30;
    bus.req_addr = {32'h0, 32'h100, 32'h0, 32'h0};
    bus.req_wdata = {32'h0, 32'hA5A5A5A5, 32'h0, 32'h0};
    bus.req_valid = 4'b0100; #1;
    chk("e_ready", bus.req_ready, 4'b0100);
    cyc; bus.req_valid = '0; #1;
    chk("e_snoop_valid", bus.snoop_valid, 0);
    chk("e_mem_wr", bus.mem_wr, 1);
    chk("e_mem_wdata", bus.mem_wdata, 32'hA5A5A5A5);
    chk("e_mem_addr", bus.mem_addr, 32'h100);
    bus.mem_ack = 1'b1;
    cyc; bus.mem_ack = 1'b0; #1;
    chk("e_resp_valid", bus.resp_valid, 4'b0100);
    chk("e_resp_data", bus.resp_data, 0);
    cyc;

    // Reset during MEM of a core1 BusRd, then core0 wins over core1
    bus.req_op = 8'h00;
    bus.req_addr = {32'h0, 32'h0, 32'h200, 32'h300};
    bus.snoop_done = 4'b1101;
    bus.req_valid = 4'b0010; #1;
    chk("f_ready", bus.req_ready, 4'b0010);
    cyc; bus.req_valid = '0;
    cyc; #1;
    chk("f_mem_rd", bus.mem_rd, 1);
    reset = 1'b1; bus.req_valid = 4'b0011;
    cyc; #1;
    chk("f_mem_rd_drop", bus.mem_rd, 0);
    chk("f_no_resp", bus.resp_valid, 0);
    reset = 1'b0; bus.snoop_done = 4'b1110; #1;
    chk("f_grant0", bus.req_ready, 4'b0001);
    cyc; bus.req_valid = '0; #1;
    chk("f_snoop_src", bus.snoop_src, 0);
    cyc; bus.mem_rdata = 32'hCAFEF00D; bus.mem_ack = 1'b1; #1;
    chk("f_mem_addr", bus.mem_addr, 32'h300);
    cyc; bus.mem_ack = 1'b0; #1;
    chk("f_resp_valid", bus.resp_valid, 4'b0001);
    chk("f_resp_data", bus.resp_data, 32'hCAFEF00D);
    cyc;
    chk("never_rd_and_wr", both_cycles, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
